// File: rtl/pc_fetch_if.sv
// pc_fetch_if: redirect, instruction-memory and decode handshake signals of the fetch sequencer
interface pc_fetch_if;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic [31:0] pc;
  modport master (
    input  redirect_valid, redirect_target, imem_gnt, imem_rvalid, imem_rdata, if_ready,
    output imem_req, imem_addr, if_valid, if_instr, if_pc, pc
  );
  modport slave (
    output redirect_valid, redirect_target, imem_gnt, imem_rvalid, imem_rdata, if_ready,
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, pc
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter owner issuing one outstanding instruction fetch at a time
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          XLEN         = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  pc_fetch_if.master bus
);
  typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;
  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, instr_q, instr_d, if_pc_q, if_pc_d, tgt;
  logic            drop_q, drop_d;
  assign tgt = bus.redirect_target & ~32'h3;
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    instr_d  = instr_q;
    if_pc_d  = if_pc_q;
    drop_d   = drop_q;
    if (bus.redirect_valid) pc_d = tgt;
    case (state_q)
      BOOT: state_d = REQ;
      REQ: if (bus.imem_gnt) begin
        state_d = WAIT;
        // a grant racing a redirect fetches the old path, so its response must be thrown away
        drop_d  = bus.redirect_valid;
        if (!bus.redirect_valid) begin
          rsp_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
        end
      end
      WAIT: if (bus.imem_rvalid) begin
        drop_d  = 1'b0;
        state_d = (drop_q || bus.redirect_valid) ? REQ : HOLD;
        if (!drop_q && !bus.redirect_valid) begin
          instr_d = bus.imem_rdata;
          if_pc_d = rsp_pc_q;
        end
      end else if (bus.redirect_valid) drop_d = 1'b1;
      HOLD: state_d = (bus.if_ready || bus.redirect_valid) ? REQ : HOLD;
      default: state_d = BOOT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= BOOT;
      pc_q     <= RESET_VECTOR;
      rsp_pc_q <= '0;
      instr_q  <= '0;
      if_pc_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      instr_q  <= instr_d;
      if_pc_q  <= if_pc_d;
      drop_q   <= drop_d;
    end
  assign bus.imem_req  = state_q == REQ;
  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = state_q == HOLD;
  assign bus.if_instr  = instr_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.pc        = pc_q;
endmodule
